// File: rtl/trb_rw_scheduler_pkg.sv
// Shared constants and types for the trace-memory read/write slot scheduler.
package trb_rw_scheduler_pkg;

    localparam int TRB_DEPTH     = 8;
    localparam int TRB_MAX_BURST = 4;

    typedef enum logic {
        SLOT_READ  = 1'b0,
        SLOT_WRITE = 1'b1
    } rw_slot_t;

endpackage

// File: rtl/trb_rw_scheduler_if.sv
// Control and status bundle between the logger and the read/write slot scheduler.
interface trb_rw_scheduler_if #(
    parameter int DEPTH = 8
);
    localparam int FW = $clog2(DEPTH) + 1;

    logic          enable_i;
    logic          flush_i;
    logic          overwrite_i;
    logic          write_req_i;
    logic          read_req_i;
    logic          rw_turn_o;
    logic          write_allow_o;
    logic          read_allow_o;
    logic [FW-1:0] fill_o;
    logic          full_o;
    logic          empty_o;
    logic          drop_o;

    modport master (
        output enable_i, flush_i, overwrite_i, write_req_i, read_req_i,
        input  rw_turn_o, write_allow_o, read_allow_o, fill_o, full_o, empty_o, drop_o
    );

    modport slave (
        input  enable_i, flush_i, overwrite_i, write_req_i, read_req_i,
        output rw_turn_o, write_allow_o, read_allow_o, fill_o, full_o, empty_o, drop_o
    );

endinterface

// File: rtl/trb_rw_scheduler_fill_counter.sv
// Occupancy counter for the trace memory: 0..DEPTH with clear, hold-on-full
// for overwrite writes, and registered full/empty flags.
module trb_fill_counter #(
    parameter int DEPTH = 8,
    localparam int FW   = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clear_i,
    input  logic          incr_i,
    input  logic          decr_i,
    input  logic          hold_i,
    output logic [FW-1:0] fill_o,
    output logic          full_o,
    output logic          empty_o
);

    logic [FW-1:0] fill_q, fill_d;
    logic          full_q, empty_q;

    // An overwrite write replaces the oldest entry, so occupancy stays put.
    always_comb begin
        fill_d = fill_q;
        if (clear_i) begin
            fill_d = '0;
        end else if (incr_i && !hold_i) begin
            fill_d = fill_q + FW'(1);
        end else if (decr_i) begin
            fill_d = fill_q - FW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fill_q  <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            fill_q  <= fill_d;
            full_q  <= (fill_d == FW'(DEPTH));
            empty_q <= (fill_d == '0);
        end
    end

    assign fill_o  = fill_q;
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/trb_rw_scheduler.sv
// Weighted round-robin slot scheduler for the single-port trace memory:
// at most one read or write grant per cycle, bounded by occupancy.
module trb_rw_scheduler
    import trb_rw_scheduler_pkg::*;
#(
    parameter int DEPTH     = TRB_DEPTH,
    parameter int MAX_BURST = TRB_MAX_BURST
) (
    input  logic                clk_i,
    input  logic                rst_i,
    trb_rw_scheduler_if.slave   bus
);

    localparam int FW = $clog2(DEPTH) + 1;
    localparam int CW = $clog2(MAX_BURST + 1);

    rw_slot_t      lastSlot_q, lastSlot_d;
    logic [CW-1:0] burstCnt_q, burstCnt_d;
    logic          writeAllow_q, readAllow_q, drop_q;

    logic [FW-1:0] fill;
    logic          full, empty;
    logic          writeElig, readElig, grantWrite, grantRead, burstOpen;
    rw_slot_t      grantSlot;

    assign writeElig = bus.write_req_i && (!full || bus.overwrite_i);
    assign readElig  = bus.read_req_i && !empty;
    assign burstOpen = (burstCnt_q < CW'(MAX_BURST));

    // With both sides eligible the last type keeps the slot until its burst is spent.
    always_comb begin
        grantWrite = 1'b0;
        grantRead  = 1'b0;
        if (bus.enable_i && !bus.flush_i) begin
            if (writeElig && readElig) begin
                if ((lastSlot_q == SLOT_WRITE) == burstOpen) begin
                    grantWrite = 1'b1;
                end else begin
                    grantRead = 1'b1;
                end
            end else begin
                grantWrite = writeElig;
                grantRead  = readElig;
            end
        end
    end

    assign grantSlot = grantWrite ? SLOT_WRITE : SLOT_READ;

    always_comb begin
        lastSlot_d = lastSlot_q;
        burstCnt_d = burstCnt_q;
        if (bus.flush_i) begin
            lastSlot_d = SLOT_WRITE;
            burstCnt_d = '0;
        end else if (grantWrite || grantRead) begin
            if (grantSlot == lastSlot_q) begin
                if (burstOpen) begin
                    burstCnt_d = burstCnt_q + CW'(1);
                end
            end else begin
                lastSlot_d = grantSlot;
                burstCnt_d = CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lastSlot_q   <= SLOT_WRITE;
            burstCnt_q   <= '0;
            writeAllow_q <= 1'b0;
            readAllow_q  <= 1'b0;
            drop_q       <= 1'b0;
        end else begin
            lastSlot_q   <= lastSlot_d;
            burstCnt_q   <= burstCnt_d;
            writeAllow_q <= grantWrite;
            readAllow_q  <= grantRead;
            drop_q       <= grantWrite && full;
        end
    end

    trb_fill_counter #(
        .DEPTH (DEPTH)
    ) u_fill (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (bus.flush_i),
        .incr_i  (grantWrite),
        .decr_i  (grantRead),
        .hold_i  (grantWrite && full),
        .fill_o  (fill),
        .full_o  (full),
        .empty_o (empty)
    );

    assign bus.rw_turn_o     = lastSlot_q;
    assign bus.write_allow_o = writeAllow_q;
    assign bus.read_allow_o  = readAllow_q;
    assign bus.drop_o        = drop_q;
    assign bus.fill_o        = fill;
    assign bus.full_o        = full;
    assign bus.empty_o       = empty;

endmodule

// File: tb/tb_trb_rw_scheduler.sv
// Scoreboard bench for trb_rw_scheduler with DEPTH=8, MAX_BURST=2.
module tb_trb_rw_scheduler;

    localparam int DEPTH = 8;

    typedef struct {
        logic [9:0] vec;
        string      name;
    } exp_t;

    logic clk;
    logic rst;
    int   compared;
    int   mismatched;
    exp_t expQ[$];

    trb_rw_scheduler_if #(.DEPTH(DEPTH)) bus ();

    trb_rw_scheduler #(
        .DEPTH     (DEPTH),
        .MAX_BURST (2)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic applyStimulus(input logic r, input logic en, input logic fl, input logic ow,
                                 input logic wr, input logic rd, input logic ewa, input logic era,
                                 input logic eturn, input int efill, input logic edrop,
                                 input string nm);
        exp_t e;
        @(negedge clk);
        rst             = r;
        bus.enable_i    = en;
        bus.flush_i     = fl;
        bus.overwrite_i = ow;
        bus.write_req_i = wr;
        bus.read_req_i  = rd;
        e.vec  = {ewa, era, eturn, efill[3:0], edrop, (efill == DEPTH), (efill == 0)};
        e.name = nm;
        expQ.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        logic [9:0] act;
        act = {bus.write_allow_o, bus.read_allow_o, bus.rw_turn_o, bus.fill_o,
               bus.drop_o, bus.full_o, bus.empty_o};
        compared++;
        if (act !== e.vec) begin
            mismatched++;
            $display("[TB] FAIL %s: got wa=%b ra=%b turn=%b fill=%0d drop=%b full=%b empty=%b, expected wa=%b ra=%b turn=%b fill=%0d drop=%b full=%b empty=%b",
                     e.name, act[9], act[8], act[7], act[6:3], act[2], act[1], act[0],
                     e.vec[9], e.vec[8], e.vec[7], e.vec[6:3], e.vec[2], e.vec[1], e.vec[0]);
        end
    endtask

    // Monitor: compare once per edge, after the registered outputs settle.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                checkOutput(expQ.pop_front());
            end
        end
    end

    initial begin
        compared        = 0;
        mismatched      = 0;
        rst             = 1'b1;
        bus.enable_i    = 1'b1;
        bus.flush_i     = 1'b0;
        bus.overwrite_i = 1'b0;
        bus.write_req_i = 1'b0;
        bus.read_req_i  = 1'b0;

        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, "reset0");
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, "reset1");

        // Both requesting: empty forces write first, then bursts of two alternate.
        applyStimulus(0, 1, 0, 0, 1, 1, 1, 0, 1, 1, 0, "both_w1");
        applyStimulus(0, 1, 0, 0, 1, 1, 1, 0, 1, 2, 0, "both_w2");
        applyStimulus(0, 1, 0, 0, 1, 1, 0, 1, 0, 1, 0, "both_r1");
        applyStimulus(0, 1, 0, 0, 1, 1, 0, 1, 0, 0, 0, "both_r2");
        applyStimulus(0, 1, 0, 0, 1, 1, 1, 0, 1, 1, 0, "both_w3");
        applyStimulus(0, 1, 0, 0, 1, 1, 1, 0, 1, 2, 0, "both_w4");
        applyStimulus(0, 1, 0, 0, 1, 1, 0, 1, 0, 1, 0, "both_r3");
        applyStimulus(0, 1, 0, 0, 1, 1, 0, 1, 0, 0, 0, "both_r4");
        applyStimulus(1, 1, 0, 0, 1, 1, 0, 0, 1, 0, 0, "reset_mid");

        for (int i = 1; i <= 8; i++)
            applyStimulus(0, 1, 0, 0, 1, 0, 1, 0, 1, i, 0, "fill_w");
        applyStimulus(0, 1, 0, 0, 1, 0, 0, 0, 1, 8, 0, "full_stall9");
        applyStimulus(0, 1, 0, 0, 1, 0, 0, 0, 1, 8, 0, "full_stall10");

        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, "reset_ow");
        for (int i = 1; i <= 8; i++)
            applyStimulus(0, 1, 0, 1, 1, 0, 1, 0, 1, i, 0, "ow_fill_w");
        applyStimulus(0, 1, 0, 1, 1, 0, 1, 0, 1, 8, 1, "ow_drop9");
        applyStimulus(0, 1, 0, 1, 1, 0, 1, 0, 1, 8, 1, "ow_drop10");

        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, "reset_rd");
        for (int i = 0; i < 3; i++)
            applyStimulus(0, 1, 0, 0, 0, 1, 0, 0, 1, 0, 0, "rd_empty");
        applyStimulus(0, 1, 0, 0, 1, 1, 1, 0, 1, 1, 0, "empty_both_w");
        applyStimulus(0, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0, "rd_after_w");
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "idle_hold_turn");

        for (int i = 1; i <= 5; i++)
            applyStimulus(0, 1, 0, 0, 1, 0, 1, 0, 1, i, 0, "pre_flush_w");
        applyStimulus(0, 1, 1, 0, 1, 1, 0, 0, 1, 0, 0, "flush");
        applyStimulus(0, 1, 0, 0, 1, 1, 1, 0, 1, 1, 0, "post_flush_w1");
        applyStimulus(0, 1, 0, 0, 1, 1, 1, 0, 1, 2, 0, "post_flush_w2");
        applyStimulus(0, 1, 0, 0, 1, 1, 0, 1, 0, 1, 0, "post_flush_r1");

        for (int i = 0; i < 4; i++)
            applyStimulus(0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0, "disabled");
        applyStimulus(0, 1, 0, 0, 1, 1, 0, 1, 0, 0, 0, "reenable_r2");
        applyStimulus(0, 1, 0, 0, 1, 1, 1, 0, 1, 1, 0, "reenable_w1");
        applyStimulus(0, 1, 0, 0, 1, 1, 1, 0, 1, 2, 0, "reenable_w2");
        applyStimulus(1, 1, 0, 0, 1, 1, 0, 0, 1, 0, 0, "reset_burst");
        applyStimulus(0, 1, 0, 0, 1, 1, 1, 0, 1, 1, 0, "after_reset_w");
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, "final_idle");

        for (int i = 0; i < 10 && expQ.size() > 0; i++)
            @(posedge clk);
        #2;
        if (expQ.size() > 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL drain: got %0d pending, expected 0 pending", expQ.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
